// File: rtl/l2_ram_pkg.sv
// rtl/l2_ram_pkg.sv - shared types and constants for the multi-bank L2 RAM
package l2_ram_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        DRAIN = 2'd1,
        RUN   = 2'd2
    } l2_state_e;

    localparam int unsigned MAX_MEM_LATENCY    = 4;
    localparam logic [31:0] ERR_RDATA          = 32'hBADACCE5;
    localparam logic [31:0] DEFAULT_START_ADDR = 32'h1C01_0000;

endpackage

// File: rtl/l2_ram_bank_port.sv
// rtl/l2_ram_bank_port.sv - one interleaved bank: range check, macro, response pipeline
module l2_ram_bank_port import l2_ram_pkg::*; #(
  parameter int unsigned BANK_WORDS  = 32768,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] START_ADDR  = DEFAULT_START_ADDR,
  parameter int unsigned AW          = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          sweep_i,
  input  logic [AW-1:0] sweep_addr_i,
  input  logic          req_i,
  input  logic [31:0]   add_i,
  input  logic          wen_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic          gnt_o,
  output logic          r_valid_o,
  output logic          r_opc_o,
  output logic [31:0]   r_rdata_o,
  output logic          busy_o
);

  localparam logic [32:0] RANGE_BYTES = 33'(BANK_WORDS) << 2;

  logic [31:0]   off;
  logic          in_range;
  logic          acc;
  logic          cen;
  logic          wen_m;
  logic [3:0]    ben;
  logic [AW-1:0] addr;
  logic [31:0]   wdata_m;
  logic [31:0]   mem_rdata;
  logic          v0;
  logic          e0;
  logic [31:0]   rdata0;

  // Offset wraps modulo 2^32, so addresses below START_ADDR land out of range.
  assign off      = add_i - START_ADDR;
  assign in_range = ({1'b0, off} < RANGE_BYTES);
  assign gnt_o    = en_i & req_i;
  assign acc      = gnt_o & in_range;

  // The sweep owns the macro while the top is clearing; it never overlaps RUN.
  assign cen     = ~(sweep_i | acc);
  assign wen_m   = sweep_i ? 1'b0 : wen_i;
  assign ben     = sweep_i ? 4'b0000 : ~be_i;
  assign addr    = sweep_i ? sweep_addr_i : off[AW+1:2];
  assign wdata_m = sweep_i ? 32'h0 : wdata_i;

`ifdef PULP_FPGA_EMUL
  fpga_interleaved_ram #(
    .ADDR_WIDTH (AW)
  ) i_ram (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .csn_i   (cen),
    .wen_i   (wen_m),
    .be_i    (~ben),
    .addr_i  (addr),
    .wdata_i (wdata_m),
    .rdata_o (mem_rdata)
  );
`else
  logic [31:0] mem_q [BANK_WORDS];

  // Single-port macro model: active-low chip/byte enables, read data held until next read.
  always_ff @(posedge clk_i) begin
    if (!cen) begin
      if (wen_m) begin
        mem_rdata <= mem_q[addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (!ben[b]) mem_q[addr][8*b +: 8] <= wdata_m[8*b +: 8];
        end
      end
    end
  end
`endif

  // First response stage runs alongside the macro read: valid plus error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v0 <= 1'b0;
      e0 <= 1'b0;
    end else begin
      v0 <= gnt_o;
      e0 <= gnt_o & ~in_range;
    end
  end

  assign rdata0 = e0 ? ERR_RDATA : mem_rdata;

  if (MEM_LATENCY <= 1) begin : g_lat1
    assign r_valid_o = v0;
    assign r_opc_o   = e0;
    assign r_rdata_o = rdata0;
    assign busy_o    = v0;
  end else begin : g_pipe
    localparam int unsigned NS = MEM_LATENCY - 1;
    logic [NS-1:0]       pv;
    logic [NS-1:0]       po;
    logic [NS-1:0][31:0] pd;

    // Extra output stages delay the whole response tuple to the configured latency.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        pv <= '0;
        po <= '0;
        pd <= '0;
      end else begin
        pv[0] <= v0;
        po[0] <= e0;
        pd[0] <= rdata0;
        for (int s = 1; s < NS; s++) begin
          pv[s] <= pv[s-1];
          po[s] <= po[s-1];
          pd[s] <= pd[s-1];
        end
      end
    end

    assign r_valid_o = pv[NS-1];
    assign r_opc_o   = po[NS-1];
    assign r_rdata_o = pd[NS-1];
    assign busy_o    = v0 | (|pv);
  end

endmodule

// File: rtl/l2_ram_multi_bank_pl.sv
// rtl/l2_ram_multi_bank_pl.sv - interleaved L2 RAM with latency pipeline, error response and zero sweep
module l2_ram_multi_bank_pl import l2_ram_pkg::*; #(
  parameter int unsigned NB_BANKS       = 4,
  parameter int unsigned BANK_WORDS     = 32768,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter logic [31:0] START_ADDR     = DEFAULT_START_ADDR,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      init_ni,
  input  logic                      test_mode_i,
  output logic                      init_done_o,
  input  logic [NB_BANKS-1:0]       mem_req,
  input  logic [NB_BANKS-1:0][31:0] mem_add,
  input  logic [NB_BANKS-1:0]       mem_wen,
  input  logic [NB_BANKS-1:0][3:0]  mem_be,
  input  logic [NB_BANKS-1:0][31:0] mem_wdata,
  output logic [NB_BANKS-1:0]       mem_gnt,
  output logic [NB_BANKS-1:0]       mem_r_valid,
  output logic [NB_BANKS-1:0]       mem_r_opc,
  output logic [NB_BANKS-1:0][31:0] mem_r_rdata
);

  localparam int unsigned AW = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(BANK_WORDS - 1);

  l2_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          sweep, run_en;
  logic          sweep_en, grant_en;
  logic [NB_BANKS-1:0] busy;

  // State and sweep counter; reset lands in INIT (sweep) or straight in RUN.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CLEAR_ON_RESET ? INIT : RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep one word per cycle, serve in RUN, drain before re-clearing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sweep   = 1'b0;
    run_en  = 1'b0;
    case (state_q)
      INIT: begin
        if (test_mode_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          sweep = 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!(|busy)) state_d = INIT;
      end
      RUN: begin
        run_en = 1'b1;
        if (!init_ni) state_d = DRAIN;
      end
      default: state_d = INIT;
    endcase
  end

  // No grant and no macro activity while reset is held.
  assign sweep_en    = sweep & rst_ni;
  assign grant_en    = run_en & rst_ni;
  assign init_done_o = (state_q == RUN);

  for (genvar i = 0; i < NB_BANKS; i++) begin : g_bank
    l2_ram_bank_port #(
      .BANK_WORDS  (BANK_WORDS),
      .MEM_LATENCY (MEM_LATENCY),
      .START_ADDR  (START_ADDR),
      .AW          (AW)
    ) i_port (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .en_i         (grant_en),
      .sweep_i      (sweep_en),
      .sweep_addr_i (cnt_q),
      .req_i        (mem_req[i]),
      .add_i        (mem_add[i]),
      .wen_i        (mem_wen[i]),
      .be_i         (mem_be[i]),
      .wdata_i      (mem_wdata[i]),
      .gnt_o        (mem_gnt[i]),
      .r_valid_o    (mem_r_valid[i]),
      .r_opc_o      (mem_r_opc[i]),
      .r_rdata_o    (mem_r_rdata[i]),
      .busy_o       (busy[i])
    );
  end

endmodule

// File: tb/tb_l2_ram_multi_bank_pl.sv
// tb/tb_l2_ram_multi_bank_pl.sv - directed bench over four instances with latency 1..4
module tb_l2_ram_multi_bank_pl;

  localparam int NB = 4;
  localparam int BW = 16;
  localparam logic [31:0] SA  = 32'h1C01_0000;
  localparam logic [31:0] ERR = 32'hBADACCE5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_ni, init_ni, test_mode;
  logic [NB-1:0]       req, wen;
  logic [NB-1:0][31:0] add, wdata;
  logic [NB-1:0][3:0]  be;

  logic                t_done [4];
  logic [NB-1:0]       t_gnt  [4];
  logic [NB-1:0]       t_rv   [4];
  logic [NB-1:0]       t_ro   [4];
  logic [NB-1:0][31:0] t_rd   [4];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl      [NB][BW];
  logic [31:0] exp_rd   [NB][100];
  bit          exp_isrd [NB][100];
  int          cnt      [4][NB];
  int          zc       [4];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    l2_ram_multi_bank_pl #(
      .NB_BANKS       (NB),
      .BANK_WORDS     (BW),
      .MEM_LATENCY    (k + 1),
      .START_ADDR     (SA),
      .CLEAR_ON_RESET (1'b1)
    ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .init_ni     (init_ni),
      .test_mode_i (test_mode),
      .init_done_o (t_done[k]),
      .mem_req     (req),
      .mem_add     (add),
      .mem_wen     (wen),
      .mem_be      (be),
      .mem_wdata   (wdata),
      .mem_gnt     (t_gnt[k]),
      .mem_r_valid (t_rv[k]),
      .mem_r_opc   (t_ro[k]),
      .mem_r_rdata (t_rd[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on bank b, then check grant and the response window on every instance.
  task automatic single(input int b, input logic [31:0] a, input logic w, input logic [3:0] bev,
                        input logic [31:0] wd, input logic [31:0] erd, input logic eopc,
                        input bit crd, input string tag);
    @(posedge clk); #1;
    req = '0; req[b] = 1'b1; add[b] = a; wen[b] = w; be[b] = bev; wdata[b] = wd;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_gnt_L%0d", tag, k + 1), 32'(t_gnt[k]), 32'(1 << b));
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      req = '0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("%s_valid_L%0d_c%0d", tag, k + 1, c), 32'(t_rv[k]), (c == k + 1) ? 32'(1 << b) : 32'h0);
        if (c == k + 1) begin
          chk($sformatf("%s_opc_L%0d", tag, k + 1), 32'(t_ro[k][b]), 32'(eopc));
          if (crd) chk($sformatf("%s_rdata_L%0d", tag, k + 1), t_rd[k][b], erd);
        end
      end
    end
  endtask

  initial begin
    int idx;
    int n;
    bit e;
    rst_ni = 1'b0; init_ni = 1'b1; test_mode = 1'b0;
    req = '0; wen = '1; add = '0; wdata = '0; be = '0;

    // Reset state, with requests pending during reset.
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    req = '1; for (int b = 0; b < NB; b++) add[b] = SA;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_gnt_L%0d", k + 1), 32'(t_gnt[k]), 32'h0);
      chk($sformatf("rst_valid_L%0d", k + 1), 32'(t_rv[k]), 32'h0);
      chk($sformatf("rst_opc_L%0d", k + 1), 32'(t_ro[k]), 32'h0);
      chk($sformatf("rst_done_L%0d", k + 1), 32'(t_done[k]), 32'h0);
      if (k > 0) chk($sformatf("rst_rdata_L%0d", k + 1), t_rd[k][0], 32'h0);
    end

    // Reset sweep: 16 cycles with init_done low and no grants, then RUN.
    @(posedge clk); #1; rst_ni = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == 16) req = '0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("sweep_done_L%0d_c%0d", k + 1, i), 32'(t_done[k]), (i == 16) ? 32'h1 : 32'h0);
        if (i < 16) chk($sformatf("sweep_gnt_L%0d_c%0d", k + 1, i), 32'(t_gnt[k]), 32'h0);
      end
    end

    single(2, SA + 32'd20, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, "rd_b2_w5");
    single(1, SA + 32'd8, 1'b0, 4'b0101, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "wr_be0101");
    single(1, SA + 32'd8, 1'b1, 4'hF, 32'h0, 32'h00AD00EF, 1'b0, 1'b1, "rd_be0101");
    single(0, SA + 32'd64, 1'b0, 4'hF, 32'hFFFFFFFF, ERR, 1'b1, 1'b1, "oor_hi");
    single(0, SA - 32'd4, 1'b1, 4'hF, 32'h0, ERR, 1'b1, 1'b1, "oor_lo");
    single(0, SA, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, "w0_after_oor");
    single(0, SA + 32'd60, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, "rd_last_word");

    // Back-to-back random traffic on all banks against a reference model.
    for (int b = 0; b < NB; b++) for (int i = 0; i < BW; i++) mdl[b][i] = 32'h0;
    mdl[1][2] = 32'h00AD00EF;
    for (int k = 0; k < 4; k++) for (int b = 0; b < NB; b++) cnt[k][b] = 0;
    for (int c = 0; c < 104; c++) begin
      @(posedge clk); #1;
      if (c < 100) begin
        for (int b = 0; b < NB; b++) begin
          idx = $urandom_range(BW - 1, 0);
          req[b] = 1'b1; add[b] = SA + 32'(idx * 4); wen[b] = 1'($urandom_range(1, 0));
          be[b] = 4'($urandom); wdata[b] = $urandom;
          exp_isrd[b][c] = wen[b];
          exp_rd[b][c] = mdl[b][idx];
          if (!wen[b]) for (int j = 0; j < 4; j++) if (be[b][j]) mdl[b][idx][8*j +: 8] = wdata[b][8*j +: 8];
        end
      end else begin
        req = '0;
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (c < 100) chk($sformatf("bb_gnt_L%0d_c%0d", k + 1, c), 32'(t_gnt[k]), 32'hF);
        for (int b = 0; b < NB; b++) begin
          if (t_rv[k][b] === 1'b1) begin
            n = cnt[k][b];
            chk($sformatf("bb_order_L%0d_b%0d", k + 1, b), 32'(n), 32'(c - (k + 1)));
            if (n < 100) begin
              chk($sformatf("bb_opc_L%0d_b%0d", k + 1, b), 32'(t_ro[k][b]), 32'h0);
              if (exp_isrd[b][n]) chk($sformatf("bb_rdata_L%0d_b%0d_n%0d", k + 1, b, n), t_rd[k][b], exp_rd[b][n]);
            end
            cnt[k][b]++;
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) for (int b = 0; b < NB; b++)
      chk($sformatf("bb_count_L%0d_b%0d", k + 1, b), 32'(cnt[k][b]), 32'd100);

    // Clear request with three reads in flight.
    for (int b = 0; b < NB; b++) single(b, SA + 32'd12, 1'b0, 4'hF, 32'hA5A50000 | 32'(b), 32'h0, 1'b0, 1'b0, "wr_w3");
    for (int k = 0; k < 4; k++) zc[k] = 0;
    for (int it = 0; it < 40; it++) begin
      @(posedge clk); #1;
      if (it <= 3) begin req = '0; req[0] = 1'b1; add[0] = SA + 32'd12; wen[0] = 1'b1; end
      else req = '0;
      init_ni = (it == 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (it <= 2) chk($sformatf("clr_gnt_L%0d_c%0d", k + 1, it), 32'(t_gnt[k]), 32'h1);
        if (it == 3) chk($sformatf("clr_gnt_off_L%0d", k + 1), 32'(t_gnt[k]), 32'h0);
        e = (it - (k + 1) >= 0) && (it - (k + 1) <= 2);
        chk($sformatf("clr_valid_L%0d_c%0d", k + 1, it), 32'(t_rv[k]), e ? 32'h1 : 32'h0);
        if (e) begin
          chk($sformatf("clr_rdata_L%0d_c%0d", k + 1, it), t_rd[k][0], 32'hA5A50000);
          chk($sformatf("clr_opc_L%0d_c%0d", k + 1, it), 32'(t_ro[k][0]), 32'h0);
        end
        if (it >= 3 && t_done[k] !== 1'b1) zc[k]++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("clr_done_L%0d", k + 1), 32'(t_done[k]), 32'h1);
      chk($sformatf("clr_len_L%0d", k + 1), 32'(zc[k] >= BW + 1 && zc[k] <= BW + k + 3), 32'h1);
    end
    single(0, SA + 32'd12, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, "clr_b0_w3");
    single(3, SA + 32'd12, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, "clr_b3_w3");
    single(1, SA + 32'd8, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, "clr_b1_w2");

    // Reset in the sweep cycle that would clear word 7, then restart in test mode.
    for (int w = 6; w <= 8; w++) single(1, SA + 32'(w * 4), 1'b0, 4'hF, 32'h11111100 | 32'(w), 32'h0, 1'b0, 1'b0, "pre_b1");
    single(2, SA + 32'd60, 1'b0, 4'hF, 32'h2222220F, 32'h0, 1'b0, 1'b0, "pre_b2");
    @(posedge clk); #1; rst_ni = 1'b0;
    @(posedge clk); #1; rst_ni = 1'b1;
    for (int i = 0; i < 7; i++) begin @(posedge clk); #1; end
    rst_ni = 1'b0; test_mode = 1'b1;
    @(posedge clk); #1; rst_ni = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("tm_init_L%0d", k + 1), 32'(t_done[k]), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("tm_done_L%0d", k + 1), 32'(t_done[k]), 32'h1);
    single(1, SA + 32'd24, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, "ms_b1_w6");
    single(1, SA + 32'd28, 1'b1, 4'hF, 32'h0, 32'h11111107, 1'b0, 1'b1, "ms_b1_w7");
    single(1, SA + 32'd32, 1'b1, 4'hF, 32'h0, 32'h11111108, 1'b0, 1'b1, "ms_b1_w8");
    single(2, SA + 32'd60, 1'b1, 4'hF, 32'h0, 32'h2222220F, 1'b0, 1'b1, "ms_b2_w15");

    // Reset with a response in flight: the pending response is dropped.
    @(posedge clk); #1;
    req = '0; req[0] = 1'b1; add[0] = SA; wen[0] = 1'b1;
    @(posedge clk); #1; req = '0; rst_ni = 1'b0;
    @(posedge clk); #1; rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      for (int k = 0; k < 4; k++) chk($sformatf("rstpipe_valid_L%0d_c%0d", k + 1, c), 32'(t_rv[k]), 32'h0);
    end
    single(1, SA + 32'd28, 1'b1, 4'hF, 32'h0, 32'h11111107, 1'b0, 1'b1, "tm_keep_b1_w7");
    test_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_ram_multi_bank_pl.md
# l2_ram_multi_bank_pl

Parametrised successor of the L2 multi-bank memory for the SoC interconnect. It serves NB_BANKS interleaved word-wide banks behind TCDM slave ports. It adds a configurable read-pipeline latency, an out-of-range error response, and a hardware zero-clear sweep after reset or on request. It sits between the SoC interleaved crossbar and the SRAM macros (generic_memory; fpga_interleaved_ram under PULP_FPGA_EMUL).

## Interface
- NB_BANKS, 4: number of interleaved banks/slave ports (power of two, ≥1)
- BANK_WORDS, 32768: 32-bit words per bank (power of two)
- MEM_LATENCY, 1: request-to-r_valid latency in cycles, 1..4
- START_ADDR, `SOC_MEM_MAP_TCDM_START_ADDR: byte base subtracted from `add`
- CLEAR_ON_RESET, 1: run a zero sweep after reset
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset; one clock, synchronous, active-low
- init_ni  in  1  active-low clear request, level-sensitive
- test_mode_i  in  1  1 = sweeps skipped (INIT exits in one cycle)
- init_done_o  out  1  1 = RUN state, memory accessible
- mem_slave[NB_BANKS]  XBAR_TCDM_BUS.Slave  32-bit TCDM (req, add, wen, be, wdata, gnt, r_valid, r_opc, r_rdata)

## Operation
- FSM states: INIT, DRAIN, RUN.
- Reset exit state: INIT if CLEAR_ON_RESET=1, else RUN.
- INIT: word counter w runs 0..BANK_WORDS-1, one word per cycle.
  - Every bank writes 32'h0 at w with all byte enables.
  - gnt=0 on all ports.
  - After the write at w=BANK_WORDS-1, go to RUN next cycle.
  - With test_mode_i=1, INIT goes to RUN after one cycle and writes nothing.
- RUN: gnt[i] = req[i], combinationally.
  - Per-bank byte offset off = add − START_ADDR (32-bit, wraps modulo 2^32).
  - Word index = off[AW+1:2], where AW = $clog2(BANK_WORDS). The crossbar has already stripped the bank-select bits.
  - In range (off < BANK_WORDS*4): memory access, CEN active, WEN = wen (1 = read), BEN = ~be.
  - Out of range: no memory access. Response carries r_opc=1 and r_rdata=32'hBADACCE5.
- Responses are returned for writes too (r_valid asserted, r_rdata don't-care for in-range writes). r_opc=0 on every in-range response.
- init_ni=0 sampled in RUN: gnt drops to 0 from the next cycle, and the FSM goes to DRAIN.
- DRAIN: holds until all response pipelines are empty, then goes to INIT.
- init_ni still low at the end of INIT: the FSM goes to RUN, then re-enters DRAIN on the next sample (no lockout).
- Banks are fully independent. Simultaneous requests on all ports are all granted in the same cycle.

## Timing
- Reset values: r_valid=0, r_opc=0, r_rdata=0 (pipeline registers only; the macro output is unreset), init_done_o=0 (1 if CLEAR_ON_RESET=0), counter=0.
  - gnt=0 while in reset and in INIT/DRAIN.
- Latency: request granted at cycle t → r_valid (and r_opc, r_rdata) at cycle t+MEM_LATENCY, for exactly one cycle.
  - Throughput is 1 request/cycle/bank.
- MEM_LATENCY=1: r_rdata comes directly from the macro.
  - r_valid/r_opc come from one register stage.
  - Error rdata is muxed by the registered error flag.
- MEM_LATENCY=N>1: N−1 output register stages carry {valid, opc, rdata}.
- Sweep duration: BANK_WORDS cycles. init_done_o rises in the cycle after the last clear write.
- Reset asserted mid-operation, at any state or any pipeline fill: all pipeline valids clear. Granted-but-unreturned responses are lost. The FSM restarts at its reset exit state.
- init_ni falling during an outstanding response: that response still completes in DRAIN, at the normal latency.

## Structure
- Package l2_ram_pkg holds:
  - l2_state_e {INIT, DRAIN, RUN}
  - MAX_MEM_LATENCY=4
  - ERR_RDATA=32'hBADACCE5
- Sub-module l2_ram_bank_port, one instance per bank. It contains:
  - offset/range check
  - macro instance (technology `ifdef inside)
  - latency pipeline
  - a busy_o flag (any valid in flight)
- The top level holds the FSM, the sweep counter, and the OR of busy_o flags. It drives the sweep mux into every bank port.

## Test plan
- Reset sweep, NB_BANKS=4, BANK_WORDS=16, CLEAR_ON_RESET=1: release rst_ni. Required:
  - init_done_o=0 for 16 cycles, then 1.
  - gnt=0 throughout the sweep.
  - Subsequent read of word 5, bank 2 returns 0 with r_opc=0.
- Latency sweep over MEM_LATENCY=1..4: write 32'hDEADBEEF with be=4'b0101, then read. Required:
  - Every r_valid arrives exactly MEM_LATENCY cycles after its grant.
  - Read data is 32'h00AD00EF (post-clear).
- Out of range: req with add=START_ADDR+BANK_WORDS*4. Required:
  - gnt=1.
  - After MEM_LATENCY cycles, r_valid=1, r_opc=1, r_rdata=32'hBADACCE5.
  - A later read of word 0 is unchanged.
- Back-to-back traffic: req held on all banks for 100 cycles with random in-range addresses. Required:
  - 100 responses per bank, in order.
  - Data matches the scoreboard.
- Clear request mid-traffic, MEM_LATENCY=3: pull init_ni low with 3 reads in flight. Required:
  - The 3 responses complete.
  - gnt=0 from the next cycle.
  - The sweep runs; init_done_o returns to 1 after BANK_WORDS cycles.
  - Prior data reads 0.
- Reset mid-sweep at counter=7, then test_mode_i=1. Required:
  - After reset, init_done_o=1 after one INIT cycle.
  - Words ≥7 are not cleared (read returns the pre-loaded value).
